psram_rd_fetch: RTL and testbench
=================================

Name: psram_rd_fetch

Overview:
- Read-fetch master that sits directly upstream of the PSRAM 3ch arbiter and drives one of its slave ports (S1 or S2, the display path).
- Converts a software/controller request (start address, burst count) into a sequence of fixed-length PSRAM read commands.
- Collects the returned beats into an internal FIFO and presents them as a valid/ready word stream to the pixel/line consumer.
- Issues a command only when the FIFO can absorb a whole burst, so read data is never dropped.

Parameters:
BURST_LEN, 16, rvalid beats returned per read command (matches the arbiter's 16-beat rvalid grouping)
ADDR_INC, 32, value added to addr between consecutive commands, modulo 2^23
FIFO_AW, 6, FIFO address width; depth = 2^FIFO_AW = 64 words; must be >= log2(BURST_LEN)

Ports:
psramclk  in  1  single clock (PSRAM clock domain)
rst_psclk  in  1  asynchronous active-high reset
start  in  1  1-cycle request pulse; sampled only in IDLE
start_addr  in  23  PSRAM address of first burst
num_bursts  in  16  number of read commands to issue
busy  out  1  high from accepted start until done
done  out  1  1-cycle pulse when the final beat is written to the FIFO
err  out  1  sticky stray-rvalid flag; cleared by an accepted start
cmd  out  1  to arbiter cmd_sx; constant 0 (read)
cmd_en  out  1  to arbiter cmd_en_sx; request held until cmd_ready
addr  out  23  to arbiter addr_sx
cmd_ready  in  1  from arbiter cmd_ready_sx; 1-cycle grant pulse
wdata  out  32  to arbiter wdata_sx; constant 0
mask  out  4  to arbiter mask_sx; constant 0
rdata  in  32  from arbiter rdata_sx
rvalid  in  1  from arbiter rvalid_sx
out_data  out  32  FIFO head word
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head word
fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW

Behaviour:
- Reset (async, active-high) values: state IDLE; busy=0, done=0, err=0, cmd_en=0, addr=0, FIFO empty, out_valid=0, fifo_level=0, beat count=0, remaining-burst count=0. Reset may occur mid-operation; all state is lost and any partial burst is discarded.
- State machine: IDLE, SPACE, REQ, DATA, FIN.
- IDLE:
  - start=1 with num_bursts != 0: latch addr=start_addr and remaining=num_bursts, clear err, set busy, go to SPACE.
  - start=1 with num_bursts == 0: busy stays 0, no command is issued, done pulses on the next cycle.
- SPACE: go to REQ when (2^FIFO_AW - fifo_level) >= BURST_LEN; otherwise wait. Pops only increase free space, so the reservation is safe.
- REQ:
  - cmd_en=1; addr and cmd are held stable.
  - On the edge where cmd_ready=1, go to DATA with cmd_en=0 from the next cycle, so it drops the cycle after the grant.
  - cmd_ready arriving while cmd_en=0 is ignored.
- DATA:
  - Each rvalid=1 pushes rdata into the FIFO and increments the beat count.
  - On beat BURST_LEN: decrement remaining, addr <= addr + ADDR_INC (wraps at 2^23), clear the beat count.
  - Next state is SPACE if remaining != 0, otherwise FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE. busy and done are never high together; busy falls in the same cycle done rises.
- start while not in IDLE is ignored; in-flight parameters are unaffected.
- rvalid outside DATA: data is dropped, FIFO is unchanged, err is set.
- FIFO:
  - First-word fall-through: out_data is valid whenever out_valid=1.
  - A pop occurs on out_valid & out_ready.
  - Simultaneous push and pop leaves fifo_level unchanged; data order is preserved.
  - Pointers wrap modulo 2^FIFO_AW.
  - Overflow cannot occur by construction; a pop when empty is impossible because it is gated by out_valid.
- Latency:
  - start -> cmd_en after 2 cycles when the FIFO has space (IDLE->SPACE->REQ).
  - rvalid -> out_valid after 1 cycle when the FIFO was empty.
  - Last beat -> done after 1 cycle.
- Constant outputs: cmd=0, wdata=0, mask=0 at all times.

Test Plan:
1. Reset, then start with start_addr=0x000100, num_bursts=1; arbiter grants 3 cycles after cmd_en, then returns 16 beats 0..15 -> exactly one cmd_en/cmd_ready handshake at addr=0x000100; out_data streams 0..15 with out_ready=1; done pulses once; busy falls; fifo_level returns to 0.
2. num_bursts=4, out_ready=0 throughout -> bursts 1-4 fill the FIFO to 64; no 5th command; busy stays 1 until the 4th burst, then done; addr sequence is 0x100, 0x120, 0x140, 0x160.
3. num_bursts=5, out_ready=0 until fifo_level=64, then pop 16 words -> block waits in SPACE with cmd_en=0; cmd_en rises 1 cycle after fifo_level reaches 48; 5th burst completes and done fires.
4. start_addr=0x7FFFF0, num_bursts=2 -> second command addr=0x000010 (23-bit wrap).
5. num_bursts=0 -> no cmd_en ever; done high 1 cycle after start; busy stays 0. A second start while busy is ignored and num_bursts is unchanged.
6. rvalid pulse in IDLE -> err=1, fifo_level=0; next accepted start clears err. Reset asserted mid-DATA after 7 beats -> cmd_en=0, out_valid=0, fifo_level=0 immediately.

Source files
------------

// File: rtl/psram_rd_fetch.sv
// psram_rd_fetch: splits a read request into fixed-length PSRAM read bursts and
// streams the returned beats out of a first-word-fall-through FIFO. Rev 1.0
`default_nettype none

module psram_rd_fetch #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_INC  = 32,
  parameter int FIFO_AW   = 6
) (
  input  logic               psramclk,
  input  logic               rst_psclk,
  input  logic               start,
  input  logic [22:0]        start_addr,
  input  logic [15:0]        num_bursts,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cmd,
  output logic               cmd_en,
  output logic [22:0]        addr,
  input  logic               cmd_ready,
  output logic [31:0]        wdata,
  output logic [3:0]         mask,
  input  logic [31:0]        rdata,
  input  logic               rvalid,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int                 DEPTH         = 1 << FIFO_AW;
  localparam int                 BEAT_W        = $clog2(BURST_LEN + 1);
  localparam logic [FIFO_AW:0]   LEVEL_REQ_MAX = (FIFO_AW + 1)'(DEPTH - BURST_LEN);
  localparam logic [BEAT_W-1:0]  LAST_BEAT     = BEAT_W'(BURST_LEN - 1);
  localparam logic [22:0]        ADDR_STEP     = 23'(ADDR_INC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPACE = 3'd1,
    S_REQ   = 3'd2,
    S_DATA  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [22:0]         addr_q, addr_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                err_q, err_d;

  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    level_q;
  logic [31:0]         mem_q [DEPTH];
  logic                push;
  logic                pop;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    err_d       = err_q;
    push        = 1'b0;

    // Beats arriving with no outstanding command are dropped and flagged.
    if (rvalid && (state_q != S_DATA)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_bursts != 16'd0) begin
            addr_d      = start_addr;
            remaining_d = num_bursts;
            state_d     = S_SPACE;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_SPACE: begin
        if (level_q <= LEVEL_REQ_MAX) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (cmd_ready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rvalid) begin
          push = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            remaining_d = remaining_q - 16'd1;
            addr_d      = addr_q + ADDR_STEP;
            state_d     = (remaining_q != 16'd1) ? S_SPACE : S_FIN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge psramclk or posedge rst_psclk) begin
    if (rst_psclk) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = (level_q != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge psramclk or posedge rst_psclk) begin
    if (rst_psclk) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW + 1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge psramclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rdata;
    end
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign busy       = (state_q == S_SPACE) || (state_q == S_REQ) || (state_q == S_DATA);
  assign done       = (state_q == S_FIN);
  assign cmd_en     = (state_q == S_REQ);
  assign addr       = addr_q;
  assign err        = err_q;
  assign cmd        = 1'b0;
  assign wdata      = 32'd0;
  assign mask       = 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_psram_rd_fetch.sv
// tb_psram_rd_fetch: drives psram_rd_fetch with a behavioural arbiter and consumer,
// scoring every output cycle against a transaction-level model.
`default_nettype none

module tb_psram_rd_fetch;

  localparam int BURST_LEN = 16;
  localparam int ADDR_INC  = 32;
  localparam int FIFO_AW   = 6;
  localparam int DEPTH     = 1 << FIFO_AW;

  logic              psramclk = 1'b0;
  logic              rst_psclk = 1'b1;
  logic              start = 1'b0;
  logic [22:0]       start_addr = '0;
  logic [15:0]       num_bursts = '0;
  logic              busy, done, err, cmd, cmd_en;
  logic [22:0]       addr;
  logic              cmd_ready = 1'b0;
  logic [31:0]       wdata;
  logic [3:0]        mask;
  logic [31:0]       rdata = '0;
  logic              rvalid = 1'b0;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [FIFO_AW:0]  fifo_level;

  psram_rd_fetch #(
    .BURST_LEN (BURST_LEN),
    .ADDR_INC  (ADDR_INC),
    .FIFO_AW   (FIFO_AW)
  ) dut (
    .psramclk   (psramclk),
    .rst_psclk  (rst_psclk),
    .start      (start),
    .start_addr (start_addr),
    .num_bursts (num_bursts),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cmd        (cmd),
    .cmd_en     (cmd_en),
    .addr       (addr),
    .cmd_ready  (cmd_ready),
    .wdata      (wdata),
    .mask       (mask),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level)
  );

  always #5 psramclk = ~psramclk;

  int checks = 0;
  int failures = 0;

  // Reference model: expected words in order, plus transaction bookkeeping.
  logic [31:0] q [$];
  bit          exp_cmd_en, exp_done, exp_busy, exp_err;
  bit          space_wait, requesting;
  int          grant_delay, beats_left, bursts_left;
  logic [22:0] exp_addr;
  int          ready_mode;   // 0: never ready, 1: always ready, 2: random
  int          fixed_delay = -1;
  bit          seq_data;
  int          seq_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic clear_model();
    q.delete();
    exp_cmd_en = 0; exp_done = 0; exp_busy = 0; exp_err = 0;
    space_wait = 0; requesting = 0;
    grant_delay = 0; beats_left = 0; bursts_left = 0;
    exp_addr = '0;
  endtask

  // Asserts reset between edges (after the next rising edge) and checks the
  // outputs clear without waiting for a clock.
  task automatic reset_dut();
    @(posedge psramclk);
    #2;
    rst_psclk = 1'b1;
    start = 0; cmd_ready = 0; rvalid = 0; out_ready = 0;
    #1;
    check("rst_cmd_en", cmd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", addr, 0);
    clear_model();
    @(negedge psramclk);
    rst_psclk = 1'b0;
  endtask

  task automatic step(input bit do_start, input logic [22:0] sa, input logic [15:0] nb, input bit stray);
    bit accept, nxt_cmd_en, nxt_done, nxt_busy, nxt_err, set_space, push;
    @(negedge psramclk);
    check("cmd_en", cmd_en, exp_cmd_en);
    check("done", done, exp_done);
    check("busy", busy, exp_busy);
    check("err", err, exp_err);
    check("fifo_level", fifo_level, q.size());
    check("out_valid", out_valid, (q.size() != 0));
    if (q.size() != 0) check("out_data", out_data, q[0]);
    check("const_outs", {cmd, wdata, mask}, 0);

    accept     = do_start && (bursts_left == 0) && !exp_done;
    nxt_cmd_en = 0; nxt_done = 0; nxt_busy = exp_busy; nxt_err = exp_err;
    set_space  = 0; push = 0;
    start = do_start; start_addr = sa; num_bursts = nb;
    cmd_ready = 0; rvalid = 0; rdata = $urandom;
    out_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;

    if (requesting) begin
      if (grant_delay == 0) begin
        check("cmd_addr", addr, exp_addr);
        cmd_ready  = 1;
        requesting = 0;
        beats_left = BURST_LEN;
      end else begin
        grant_delay--;
        nxt_cmd_en = 1;
      end
    end else if (space_wait) begin
      if (q.size() <= DEPTH - BURST_LEN) begin
        space_wait  = 0;
        requesting  = 1;
        nxt_cmd_en  = 1;
        grant_delay = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
      end
    end else if (beats_left > 0) begin
      if ($urandom_range(0, 3) != 0) begin
        push   = 1;
        rvalid = 1;
        if (seq_data) begin
          rdata = 32'(seq_cnt);
          seq_cnt++;
        end
        beats_left--;
        if (beats_left == 0) begin
          bursts_left--;
          exp_addr = exp_addr + 23'(ADDR_INC);
          if (bursts_left > 0) set_space = 1;
          else begin
            nxt_done = 1;
            nxt_busy = 0;
          end
        end
      end
    end else if (stray) begin
      rvalid  = 1;
      nxt_err = 1;
    end

    if (accept) begin
      nxt_err = 0;
      if (nb == 0) nxt_done = 1;
      else begin
        bursts_left = nb;
        exp_addr    = sa;
        set_space   = 1;
        nxt_busy    = 1;
      end
    end
    if (set_space) space_wait = 1;

    if (out_ready && q.size() > 0) void'(q.pop_front());
    if (push) q.push_back(rdata);
    exp_cmd_en = nxt_cmd_en; exp_done = nxt_done; exp_busy = nxt_busy; exp_err = nxt_err;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((bursts_left != 0 || exp_busy || exp_done) && n < budget) begin
      step(0, '0, '0, 0);
      n++;
    end
    check("idle_reached", (n < budget), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    ready_mode = 1;
    while (q.size() > 0 && n < budget) begin
      step(0, '0, '0, 0);
      n++;
    end
    step(0, '0, '0, 0);
    check("drained", q.size(), 0);
  endtask

  initial begin
    clear_model();
    ready_mode = 1;
    reset_dut();

    // Single burst, fixed grant latency, counting data, consumer always ready.
    fixed_delay = 3; seq_data = 1; seq_cnt = 0;
    step(1, 23'h000100, 16'd1, 0);
    run_until_idle(500);
    drain(200);
    fixed_delay = -1; seq_data = 0;

    // Four bursts with no consumer: FIFO fills exactly to capacity.
    ready_mode = 0;
    step(1, 23'h000100, 16'd4, 0);
    run_until_idle(2000);
    for (int i = 0; i < 5; i++) step(0, '0, '0, 0);
    check("full_level", fifo_level, DEPTH);
    drain(200);

    // Five bursts: stall for space, then release 16 words to let the last burst in.
    ready_mode = 0;
    step(1, 23'h000200, 16'd5, 0);
    for (int n = 0; n < 2000 && !(q.size() == DEPTH && space_wait); n++) step(0, '0, '0, 0);
    check("stall_full", q.size(), DEPTH);
    for (int i = 0; i < 8; i++) step(0, '0, '0, 0);
    ready_mode = 1;
    for (int i = 0; i < 16; i++) step(0, '0, '0, 0);
    ready_mode = 0;
    run_until_idle(2000);
    drain(200);

    // 23-bit address wrap between bursts.
    ready_mode = 2;
    step(1, 23'h7FFFF0, 16'd2, 0);
    run_until_idle(2000);
    drain(200);

    // Zero-burst request, then a start ignored while busy.
    step(1, 23'h000123, 16'd0, 0);
    run_until_idle(50);
    step(1, 23'h000400, 16'd2, 0);
    for (int i = 0; i < 6; i++) step(0, '0, '0, 0);
    step(1, 23'h000555, 16'd9, 0);
    run_until_idle(2000);
    drain(200);

    // Stray beat in IDLE, cleared by the next start; then reset mid-burst.
    step(0, '0, '0, 1);
    step(0, '0, '0, 0);
    ready_mode = 2;
    step(1, 23'h000300, 16'd3, 0);
    for (int n = 0; n < 1000 && !(beats_left > 0 && (BURST_LEN - beats_left) == 7); n++)
      step(0, '0, '0, 0);
    check("reached_beat7", BURST_LEN - beats_left, 7);
    reset_dut();
    for (int i = 0; i < 3; i++) step(0, '0, '0, 0);

    // Random transactions with a random consumer.
    for (int t = 0; t < 6; t++) begin
      ready_mode = 2;
      step(1, 23'($urandom), 16'($urandom_range(0, 3)), 0);
      run_until_idle(3000);
    end
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
